// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_cfg
//  Description : Runtime-configurable UART transmitter. Frame format (5-8
//                data bits, none/odd/even parity, 1/2 stop bits) and bit
//                divisor are latched per frame from the cfg_* inputs.
//                Optional transmit FIFO enabled by defining UART_TX_FIFO_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned UART_RATE = 1000000,
    parameter int unsigned FIFO_AW   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] cfg_div,
    input  logic [1:0]  cfg_bits,
    input  logic [1:0]  cfg_parity,
    input  logic        cfg_stop2,
    output logic        uart_txd,
    output logic        busy,
    output logic [7:0]  tx_level
);

    // Divisor value an integrator ties to cfg_div for the nominal baud rate.
    localparam int unsigned DEF_DIV = CLK_FREQ / UART_RATE - 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Reject parameter sets the FIFO pointers or divisor port cannot represent.
    generate
        if (FIFO_AW < 1 || FIFO_AW > 7 || DEF_DIV > 65535) begin : g_param_check
            $error("uart_tx_cfg: unsupported FIFO_AW or CLK_FREQ/UART_RATE");
        end
    endgenerate

    logic [2:0]  state_q,   state_d;
    logic [15:0] cnt_q,     cnt_d;      // cycles left in current bit
    logic [15:0] per_q,     per_d;      // latched bit period minus 1
    logic [2:0]  bitc_q,    bitc_d;     // data bit index / stop bit index
    logic [7:0]  shreg_q,   shreg_d;
    logic [1:0]  bits_q,    bits_d;
    logic        par_en_q,  par_en_d;
    logic        par_bit_q, par_bit_d;
    logic        stop2_q,   stop2_d;
    logic        txd_q,     txd_d;
    logic        busy_q;

    logic        w_start;               // frame start this edge
    logic [7:0]  w_start_data;
    logic [15:0] w_per_new;
    logic [7:0]  w_mask;

`ifdef UART_TX_FIFO_EN
    logic [7:0]       mem_q [2**FIFO_AW];
    logic [FIFO_AW:0] wr_q;
    logic [FIFO_AW:0] rd_q;
    logic [FIFO_AW:0] w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_push;

    assign w_empty      = (wr_q == rd_q);
    assign w_full       = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
                          (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
    assign s_ready      = !w_full;
    assign w_push       = s_valid && !w_full;
    assign w_start      = (state_q == ST_IDLE) && !w_empty;
    assign w_start_data = mem_q[rd_q[FIFO_AW-1:0]];
    assign w_level      = wr_q - rd_q;
    assign tx_level     = 8'(w_level);

    // FIFO pointers; reset flushes any queued bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (w_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (w_start) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_q[FIFO_AW-1:0]] <= s_data;
        end
    end
`else
    assign s_ready      = (state_q == ST_IDLE);
    assign w_start      = s_valid && s_ready;
    assign w_start_data = s_data;
    assign tx_level     = 8'd0;
`endif

    // Divisor 0 behaves like 1 so the shortest bit is two cycles.
    assign w_per_new = (cfg_div == 16'd0) ? 16'd1 : cfg_div;
    // Parity only sees the bits that will actually be sent.
    assign w_mask    = 8'hFF >> (3'd3 - {1'b0, cfg_bits});

    // Frame sequencer: next state, bit timing and line value.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        bitc_d    = bitc_q;
        shreg_d   = shreg_q;
        bits_d    = bits_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        txd_d     = txd_q;
        if (state_q == ST_IDLE) begin
            txd_d = 1'b1;
            if (w_start) begin
                state_d   = ST_START;
                cnt_d     = w_per_new;
                per_d     = w_per_new;
                bitc_d    = 3'd0;
                shreg_d   = w_start_data;
                bits_d    = cfg_bits;
                par_en_d  = (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
                par_bit_d = (^(w_start_data & w_mask)) ^ (cfg_parity == 2'd1);
                stop2_d   = cfg_stop2;
                txd_d     = 1'b0;
            end
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            // Bit boundary: every bit restarts the full period.
            cnt_d = per_q;
            case (state_q)
                ST_START: begin
                    state_d = ST_DATA;
                    bitc_d  = 3'd0;
                    txd_d   = shreg_q[0];
                end
                ST_DATA: begin
                    // Last data bit index is N-1 = bits_q + 4.
                    if (bitc_q == {1'b1, bits_q}) begin
                        bitc_d = 3'd0;
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            txd_d   = par_bit_q;
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bitc_d  = bitc_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        txd_d   = shreg_q[1];
                    end
                end
                ST_PARITY: begin
                    state_d = ST_STOP;
                    bitc_d  = 3'd0;
                    txd_d   = 1'b1;
                end
                ST_STOP: begin
                    txd_d = 1'b1;
                    if (stop2_q && (bitc_q == 3'd0)) begin
                        bitc_d = 3'd1;
                    end else begin
                        state_d = ST_IDLE;
                        bitc_d  = 3'd0;
                        cnt_d   = 16'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                    cnt_d   = 16'd0;
                end
            endcase
        end
    end

    // Sequencer state; reset drops any frame and drives the line idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            per_q     <= '0;
            bitc_q    <= '0;
            shreg_q   <= '0;
            bits_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            bitc_q    <= bitc_d;
            shreg_q   <= shreg_d;
            bits_q    <= bits_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            txd_q     <= txd_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign uart_txd = txd_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_cfg
//  Description : Self-checking bench for uart_tx_cfg. Expected line waveform
//                is built from the frame-format rules as a list of bit values,
//                each held for one bit period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] cfg_div = 16'd9;
    logic [1:0]  cfg_bits = 2'd3;
    logic [1:0]  cfg_parity = 2'd0;
    logic        cfg_stop2 = 1'b0;
    logic        uart_txd;
    logic        busy;
    logic [7:0]  tx_level;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_bits[$];

    uart_tx_cfg #(
        .CLK_FREQ  (100000000),
        .UART_RATE (1000000),
        .FIFO_AW   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .cfg_div    (cfg_div),
        .cfg_bits   (cfg_bits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .uart_txd   (uart_txd),
        .busy       (busy),
        .tx_level   (tx_level)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at time %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int period(input logic [15:0] div);
        return (div < 16'd2) ? 2 : int'(div) + 1;
    endfunction

    // Start bit, N data bits LSB first, optional parity, one or two stop bits.
    task automatic build_frame(input logic [7:0] d, input logic [1:0] bits,
                               input logic [1:0] par, input logic stop2);
        int n;
        int ones;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        n    = int'(bits) + 5;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par == 2'd1) exp_bits.push_back((ones % 2) == 0);
        if (par == 2'd2) exp_bits.push_back((ones % 2) == 1);
        exp_bits.push_back(1'b1);
        if (stop2) exp_bits.push_back(1'b1);
    endtask

    task automatic scramble_cfg();
        cfg_div    = 16'($urandom_range(0, 20));
        cfg_bits   = 2'($urandom);
        cfg_parity = 2'($urandom);
        cfg_stop2  = 1'($urandom);
    endtask

    // Called one step after a rising edge with the transmitter idle.
    // abort_at >= 0 pulses reset that many cycles into the frame.
    task automatic send_frame(input logic [7:0] d, input logic [15:0] div, input logic [1:0] bits,
                              input logic [1:0] par, input logic stop2, input int abort_at);
        int p;
        s_data     = d;
        cfg_div    = div;
        cfg_bits   = bits;
        cfg_parity = par;
        cfg_stop2  = stop2;
        s_valid    = 1'b1;
        check_eq("ready_idle", s_ready, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = 8'($urandom);
`ifdef UART_TX_FIFO_EN
        check_eq("fifo_gap_txd", uart_txd, 1);
        check_eq("fifo_gap_level", tx_level, 1);
        @(posedge clk); #1;
`endif
        build_frame(d, bits, par, stop2);
        p = period(div);
        scramble_cfg();
        for (int k = 0; k < exp_bits.size() * p; k++) begin
            if (k == abort_at) begin
                #3 rst_n = 1'b0;
                #1;
                check_eq("rst_txd", uart_txd, 1);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_ready", s_ready, 1);
                check_eq("rst_level", tx_level, 0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                check_eq("post_rst_txd", uart_txd, 1);
                return;
            end
            check_eq("txd", uart_txd, exp_bits[k / p]);
            check_eq("busy", busy, 1);
            if (k == 0) begin
                check_eq("level_in_frame", tx_level, 0);
`ifndef UART_TX_FIFO_EN
                check_eq("ready_in_frame", s_ready, 0);
`endif
            end
            scramble_cfg();
            @(posedge clk); #1;
        end
        check_eq("end_txd", uart_txd, 1);
        check_eq("end_busy", busy, 0);
        check_eq("end_ready", s_ready, 1);
    endtask

`ifdef UART_TX_FIFO_EN
    // Six bytes offered back-to-back on a 4-deep FIFO, 5N1 with 2-cycle bits.
    task automatic fifo_burst();
        logic [7:0] bytes [6];
        bit         wave[$];
        int         pushed;
        int         first_drop;
        int         max_level;
        for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
        cfg_div    = 16'd0;
        cfg_bits   = 2'd0;
        cfg_parity = 2'd0;
        cfg_stop2  = 1'b0;
        wave.delete();
        for (int i = 0; i < 6; i++) begin
            build_frame(bytes[i], 2'd0, 2'd0, 1'b0);
            foreach (exp_bits[b]) begin
                wave.push_back(exp_bits[b]);
                wave.push_back(exp_bits[b]);
            end
            wave.push_back(1'b1);
        end
        pushed     = 0;
        first_drop = -1;
        max_level  = 0;
        for (int j = 0; j < 2 + wave.size(); j++) begin
            if (j < 2) check_eq("burst_lead_txd", uart_txd, 1);
            else       check_eq("burst_txd", uart_txd, wave[j - 2]);
            if (int'(tx_level) > max_level) max_level = int'(tx_level);
            s_valid = (pushed < 6);
            s_data  = (pushed < 6) ? bytes[pushed] : 8'd0;
            if (s_valid && !s_ready && first_drop < 0) first_drop = pushed;
            if (s_valid && s_ready) pushed++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check_eq("burst_accepts_before_full", first_drop, 5);
        check_eq("burst_level_peak", max_level, 4);
        check_eq("burst_all_pushed", pushed, 6);
        check_eq("burst_level_end", tx_level, 0);
        check_eq("burst_busy_end", busy, 0);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        check_eq("reset_txd", uart_txd, 1);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_ready", s_ready, 1);
        check_eq("reset_level", tx_level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_frame(8'h55, 16'd9, 2'd3, 2'd0, 1'b0, -1);   // 8N1
        send_frame(8'hC1, 16'd3, 2'd2, 2'd2, 1'b1, -1);   // 7E2
        send_frame(8'h07, 16'd0, 2'd0, 2'd1, 1'b0, -1);   // 5O1, div 0
        send_frame(8'h3C, 16'd1, 2'd0, 2'd2, 1'b1, -1);   // div 1 equals div 0
        send_frame(8'hFF, 16'd9, 2'd3, 2'd0, 1'b0, 35);   // reset mid-frame
        send_frame(8'hA5, 16'd9, 2'd3, 2'd0, 1'b0, -1);   // clean frame after reset
        // Format change between frames: 8 bits then 5 bits.
        send_frame(8'hE7, 16'd2, 2'd3, 2'd0, 1'b0, -1);
        send_frame(8'hE7, 16'd2, 2'd0, 2'd0, 1'b0, -1);
        for (int i = 0; i < 20; i++) begin
            send_frame(8'($urandom), 16'($urandom_range(0, 6)), 2'($urandom),
                       2'($urandom), 1'($urandom), -1);
        end
`ifdef UART_TX_FIFO_EN
        fifo_burst();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
